// File: rtl/ysyx_22040000_regfile_sb.sv
// Multi-port integer register file with a write-pending scoreboard.
// Combinational reads with optional write bypass; synchronous writes, reservations and flush.
module ysyx_22040000_regfile_sb #(
   parameter int AWIDTH   = 5,
   parameter int DWIDTH   = 32,
   parameter int NREAD    = 2,
   parameter int NWRITE   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NWRITE-1:0]        wen,
   input  logic [NWRITE*AWIDTH-1:0] waddr,
   input  logic [NWRITE*DWIDTH-1:0] wdata,
   input  logic [NREAD*AWIDTH-1:0]  raddr,
   output logic [NREAD*DWIDTH-1:0]  rdata,
   output logic [NREAD-1:0]         rbusy,
   input  logic                     issue_valid,
   input  logic [AWIDTH-1:0]        issue_rd,
   output logic                     issue_ready,
   input  logic                     flush
);

   localparam int DEPTH = 1 << AWIDTH;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BP    = (BYPASS != 0);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic [AWIDTH-1:0] wa [NWRITE];
   logic [DWIDTH-1:0] wd [NWRITE];
   logic [NWRITE-1:0] we_eff;
   logic [AWIDTH-1:0] ra [NREAD];
   logic              issue_fire;

   always_comb begin
      for (int unsigned k = 0; k < NWRITE; k++) begin
         wa[k]     = waddr[k*AWIDTH +: AWIDTH];
         wd[k]     = wdata[k*DWIDTH +: DWIDTH];
         we_eff[k] = wen[k] & ~(ZR & (wa[k] == '0));
      end
      for (int unsigned j = 0; j < NREAD; j++) begin
         ra[j] = raddr[j*AWIDTH +: AWIDTH];
      end
   end

   always_comb begin
      issue_ready = ~flush & (~busy[issue_rd] | (ZR & (issue_rd == '0)));
      issue_fire  = issue_valid & issue_ready & ~(ZR & (issue_rd == '0));
   end

   // Ascending port order: the highest-index writer to an address lands last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else begin
         for (int unsigned k = 0; k < NWRITE; k++) begin
            if (we_eff[k]) mem[wa[k]] <= wd[k];
         end
      end
   end

   // Release first, then issue, so an issue on a released address leaves it busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         for (int unsigned k = 0; k < NWRITE; k++) begin
            if (we_eff[k]) busy[wa[k]] <= 1'b0;
         end
         if (issue_fire) busy[issue_rd] <= 1'b1;
      end
   end

   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int unsigned j = 0; j < NREAD; j++) begin
         rdata[j*DWIDTH +: DWIDTH] = mem[ra[j]];
         rbusy[j]                  = busy[ra[j]];
         if (BP) begin
            for (int unsigned k = 0; k < NWRITE; k++) begin
               if (wen[k] && (wa[k] == ra[j])) begin
                  rdata[j*DWIDTH +: DWIDTH] = wd[k];
                  rbusy[j]                  = 1'b0;
               end
            end
         end
         if ((ZR && (ra[j] == '0)) || !rst_n) begin
            rdata[j*DWIDTH +: DWIDTH] = '0;
            rbusy[j]                  = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040000_regfile_sb.sv
// Directed plus randomized bench for ysyx_22040000_regfile_sb, with and without bypass.
module tb_ysyx_22040000_regfile_sb;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NW = 2;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          w_en   [NW];
   logic [AW-1:0] w_addr [NW];
   logic [DW-1:0] w_data [NW];
   logic [AW-1:0] r_addr [NR];

   logic [NW-1:0]    wen;
   logic [NW*AW-1:0] waddr;
   logic [NW*DW-1:0] wdata;
   logic [NR*AW-1:0] raddr;
   logic             issue_valid;
   logic [AW-1:0]    issue_rd;
   logic             flush;

   logic [NR*DW-1:0] rdata_b, rdata_n;
   logic [NR-1:0]    rbusy_b, rbusy_n;
   logic             ready_b, ready_n;

   always_comb begin
      for (int k = 0; k < NW; k++) begin
         wen[k]             = w_en[k];
         waddr[k*AW +: AW]  = w_addr[k];
         wdata[k*DW +: DW]  = w_data[k];
      end
      for (int j = 0; j < NR; j++) raddr[j*AW +: AW] = r_addr[j];
   end

   ysyx_22040000_regfile_sb #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .NWRITE(NW),
                              .BYPASS(1), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(ready_b), .flush(flush));

   ysyx_22040000_regfile_sb #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .NWRITE(NW),
                              .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(ready_n), .flush(flush));

   logic [DW-1:0] m_mem  [DEPTH];
   logic          m_busy [DEPTH];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input bit byp, input int j);
      logic [DW-1:0] v;
      v = m_mem[r_addr[j]];
      if (byp)
         for (int k = 0; k < NW; k++)
            if (w_en[k] && w_addr[k] == r_addr[j]) v = w_data[k];
      if (!rst_n || r_addr[j] == 0) v = '0;
      return v;
   endfunction

   function automatic logic exp_busy(input bit byp, input int j);
      logic b;
      b = m_busy[r_addr[j]];
      if (byp)
         for (int k = 0; k < NW; k++)
            if (w_en[k] && w_addr[k] == r_addr[j]) b = 1'b0;
      if (!rst_n || r_addr[j] == 0) b = 1'b0;
      return b;
   endfunction

   function automatic logic exp_ready();
      return !flush && (!m_busy[issue_rd] || issue_rd == 0);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic check_all();
      for (int j = 0; j < NR; j++) begin
         chk($sformatf("rdata_byp%0d", j), rdata_b[j*DW +: DW], exp_data(1'b1, j));
         chk($sformatf("rbusy_byp%0d", j), {31'b0, rbusy_b[j]}, {31'b0, exp_busy(1'b1, j)});
         chk($sformatf("rdata_nobyp%0d", j), rdata_n[j*DW +: DW], exp_data(1'b0, j));
         chk($sformatf("rbusy_nobyp%0d", j), {31'b0, rbusy_n[j]}, {31'b0, exp_busy(1'b0, j)});
      end
      chk("issue_ready_byp", {31'b0, ready_b}, {31'b0, exp_ready()});
      chk("issue_ready_nobyp", {31'b0, ready_n}, {31'b0, exp_ready()});
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic tick();
      logic rdy;
      #2 check_all();
      if (rst_n) begin
         rdy = exp_ready();
         for (int k = 0; k < NW; k++)
            if (w_en[k] && w_addr[k] != 0) begin
               m_mem[w_addr[k]]  = w_data[k];
               m_busy[w_addr[k]] = 1'b0;
            end
         if (flush) for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
         else if (issue_valid && rdy && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int k = 0; k < NW; k++) begin
         w_en[k] = 1'b0; w_addr[k] = '0; w_data[k] = '0;
      end
      issue_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      w_en[k] = 1'b1; w_addr[k] = a; w_data[k] = d;
   endtask

   initial begin
      idle();
      issue_rd = '0;
      for (int j = 0; j < NR; j++) r_addr[j] = '0;
      model_clear();
      #3 check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset mid-operation
      wr(0, 5, 32'hDEAD);
      tick();
      idle(); r_addr[0] = 5; issue_valid = 1'b1; issue_rd = 5;
      #1 chk("r5_written", rdata_b[DW-1:0], 32'hDEAD);
      tick();
      idle();
      #1 chk("r5_busy_before_rst", {31'b0, rbusy_b[0]}, 32'd1);
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      chk("rst_rdata", rdata_b[DW-1:0], 32'h0);
      chk("rst_rbusy", {31'b0, rbusy_b[0]}, 32'd0);
      chk("rst_ready", {31'b0, ready_b}, 32'd1);
      check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Same-cycle double write with bypass / without
      idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); r_addr[0] = 7;
      #1;
      chk("byp_rdata", rdata_b[DW-1:0], 32'h22);
      chk("byp_rbusy", {31'b0, rbusy_b[0]}, 32'd0);
      chk("nobyp_old", rdata_n[DW-1:0], 32'h0);
      tick();
      idle();
      #1;
      chk("byp_next", rdata_b[DW-1:0], 32'h22);
      chk("nobyp_next", rdata_n[DW-1:0], 32'h22);
      tick();

      // Zero register
      idle(); wr(0, 0, 32'h5); issue_valid = 1'b1; issue_rd = 0; r_addr[0] = 0; r_addr[1] = 0;
      #1;
      chk("zero_rdata", rdata_b[DW-1:0], 32'h0);
      chk("zero_rbusy", {31'b0, rbusy_b[0]}, 32'd0);
      chk("zero_ready", {31'b0, ready_b}, 32'd1);
      tick();
      idle(); issue_rd = 0;
      #1;
      chk("zero_rdata_after", rdata_n[DW-1:0], 32'h0);
      chk("zero_rbusy_after", {31'b0, rbusy_n[0]}, 32'd0);
      chk("zero_ready_after", {31'b0, ready_b}, 32'd1);
      tick();

      // Scoreboard reserve / release / issue-vs-release
      idle(); issue_valid = 1'b1; issue_rd = 3;
      tick();
      idle(); r_addr[0] = 3; issue_rd = 3;
      #1;
      chk("sb_busy", {31'b0, rbusy_b[0]}, 32'd1);
      chk("sb_not_ready", {31'b0, ready_b}, 32'd0);
      tick();
      idle(); wr(0, 3, 32'h9);
      #1;
      chk("sb_release_byp", {31'b0, rbusy_b[0]}, 32'd0);
      chk("sb_release_nobyp", {31'b0, rbusy_n[0]}, 32'd1);
      tick();
      idle();
      #1;
      chk("sb_cleared", {31'b0, rbusy_n[0]}, 32'd0);
      chk("sb_data", rdata_n[DW-1:0], 32'h9);
      tick();
      idle(); wr(1, 3, 32'hA); issue_valid = 1'b1; issue_rd = 3;
      #1 chk("sb_ready_unres", {31'b0, ready_b}, 32'd1);
      tick();
      idle();
      #1;
      chk("sb_issue_wins_nobyp", {31'b0, rbusy_n[0]}, 32'd1);
      chk("sb_issue_wins_byp", {31'b0, rbusy_b[0]}, 32'd1);
      tick();
      idle(); wr(0, 3, 32'hB);
      tick();

      // Flush
      foreach (r_addr[j]) r_addr[j] = '0;
      for (int i = 0; i < 3; i++) begin
         idle(); issue_valid = 1'b1;
         issue_rd = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd4;
         tick();
      end
      idle(); issue_valid = 1'b1; issue_rd = 6; flush = 1'b1; r_addr[0] = 1; r_addr[1] = 2;
      #1;
      chk("flush_ready", {31'b0, ready_b}, 32'd0);
      chk("flush_busy_pre", {30'b0, rbusy_b}, 32'd3);
      tick();
      idle(); issue_rd = 6;
      #1;
      chk("flush_r1r2", {30'b0, rbusy_b}, 32'd0);
      chk("flush_r6_ready", {31'b0, ready_b}, 32'd1);
      tick();
      idle(); r_addr[0] = 4; r_addr[1] = 6;
      #1 chk("flush_r4r6", {30'b0, rbusy_n}, 32'd0);
      tick();

      // Randomized traffic on a narrow address range to force collisions
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NW; k++) begin
            w_en[k]   = ($urandom_range(0, 2) == 0);
            w_addr[k] = AW'($urandom_range(0, 7));
            w_data[k] = $urandom;
         end
         for (int j = 0; j < NR; j++) r_addr[j] = AW'($urandom_range(0, 7));
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_rd    = AW'($urandom_range(0, 7));
         flush       = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22040000_regfile_sb.md
# ysyx_22040000_regfile_sb

Parametrised multi-port integer register file with an integrated write-pending scoreboard, for the pipelined NPC core. Provides NREAD combinational read ports and NWRITE synchronous write ports, with optional write-to-read bypass and a hardwired zero register. Sits between decode/issue, which reads operands and reserves destinations, and writeback, which retires results and releases the reservations.

## Interface
- AWIDTH, 5: register address width; depth is 2**AWIDTH.
- DWIDTH, 32: data width.
- NREAD, 2: number of read ports, minimum 1.
- NWRITE, 2: number of write ports, minimum 1.
- BYPASS, 1: 1 means same-cycle write data is forwarded to the read ports; 0 disables forwarding.
- ZERO_REG, 1: 1 means entry 0 always reads 0, ignores writes and is never busy.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- wen  in  NWRITE  per-port write enable.
- waddr  in  NWRITE*AWIDTH  write addresses; port k occupies bits [k*AWIDTH +: AWIDTH].
- wdata  in  NWRITE*DWIDTH  write data; port k occupies bits [k*DWIDTH +: DWIDTH].
- raddr  in  NREAD*AWIDTH  read addresses, packed the same way.
- rdata  out  NREAD*DWIDTH  read data, combinational.
- rbusy  out  NREAD  the addressed register has a pending write that is not satisfied this cycle.
- issue_valid  in  1  request to reserve destination issue_rd.
- issue_rd  in  AWIDTH  destination register to reserve.
- issue_ready  out  1  a reservation can be accepted this cycle.
- flush  in  1  clear all reservations; used on pipeline redirect.

## Operation
- State: mem[2**AWIDTH] of DWIDTH bits, and busy[2**AWIDTH] of 1 bit each.
- Reset (rst_n=0, asynchronous): all mem entries are 0 and all busy bits are 0.
  - Outputs during reset: rdata=0 and rbusy=0; issue_ready=1 unless flush is asserted.
- Write:
  - Port k with wen[k]=1 writes mem[waddr_k] <= wdata_k at the edge.
  - When ZERO_REG=1, a write to address 0 is dropped.
  - When several ports write the same address in one cycle, the highest-index port wins.
- Read, port j:
  - rdata_j = mem[raddr_j].
  - When BYPASS=1 and some enabled write port targets raddr_j this cycle, rdata_j takes the wdata of the highest-index such port instead.
  - When ZERO_REG=1 and raddr_j=0, rdata_j=0 unconditionally.
- rbusy_j:
  - Normally rbusy_j = busy[raddr_j].
  - When BYPASS=1, rbusy_j is forced to 0 if any write port hits raddr_j this cycle.
  - rbusy_j is always 0 for address 0 when ZERO_REG=1.
- Reservation:
  - issue_ready = ~flush & (~busy[issue_rd] | (ZERO_REG & issue_rd==0)).
  - An issue fires when issue_valid & issue_ready. It sets busy[issue_rd] at the edge, except for address 0 when ZERO_REG=1.
  - This guarantees at most one outstanding write per register.
- Release: any enabled write to address a clears busy[a] at the edge.
- Simultaneous release and issue to the same address: the issue wins and busy ends at 1. This occurs only when busy was 0 beforehand, for example an unreserved write.
- flush: all busy bits are cleared at the edge. Any issue in the same cycle is ignored, since issue_ready is 0. Writes in the same cycle still update mem.
- Reset asserted mid-operation discards all pending writes, reservations and flush immediately.

## Timing
- Read latency is 0 cycles (combinational from raddr, mem, busy, and write ports when BYPASS=1).
- Write latency:
  - Data is visible through the array on the cycle after the edge.
  - With BYPASS=1 it is visible in the same cycle.
- Reservation latency:
  - busy, and therefore rbusy and issue_ready, reflect an issue from the cycle after the edge.
  - Release and flush take effect with the same one-cycle latency.
- issue_ready is combinational from issue_rd, busy and flush. issue_valid must not depend on issue_ready.
- No combinational path exists from issue_valid to any output.

## Test plan
- Reset: write 0xDEAD to r5, then pulse rst_n low mid-cycle -> rdata for r5 is 0 immediately, rbusy=0, issue_ready=1.
- Bypass: with BYPASS=1, in the same cycle wen0 writes r7=0x11, wen1 writes r7=0x22, and raddr0=r7 -> rdata0=0x22 and rbusy0=0 that cycle; r7 reads 0x22 on the next cycle.
- No bypass: with BYPASS=0, the same stimulus -> rdata0 shows the old value that cycle and 0x22 on the next cycle.
- Zero register: write 0x5 to r0 and issue r0 -> rdata=0, rbusy=0, issue_ready=1 throughout, and r0 is never busy.
- Scoreboard:
  - Issue r3 -> next cycle rbusy for r3 is 1 and issue_ready for issue_rd=r3 is 0.
  - Then write r3=0x9 -> busy clears on the next edge.
  - An issue of r3 in the same cycle as an unreserved write to r3 -> busy=1 afterwards.
- Flush: reserve r1, r2 and r4, then assert flush together with issue_valid for r6 -> next cycle all four registers are not busy, and issue_ready=0 during the flush cycle.
